// File: rtl/tx_frame_scheduler_pkg.sv
// Types and constants shared by the transmit scheduler and the Tx datapath.
package tx_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} tx_sched_state_e;

  localparam int unsigned TX_DATA_W = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Requester handshake plus Tx buffer/start/done bundle; the master side is the scheduler.
interface tx_frame_scheduler_if import tx_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = TX_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_start;
  logic                      tx_done;

  modport master (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_data, tx_start
  );

  modport slave (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_data, tx_start
  );
endinterface

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] idx;
  logic           found;

  // Explicit modulo keeps the scan in range for non-power-of-2 requester counts.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = IDW'((32'(ptr) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one serial transmitter between NUM_REQ requesters.
module tx_frame_scheduler import tx_pkg::*; #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = TX_DATA_W,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  tx_frame_scheduler_if.master       bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  input  logic                       err_clr
);
  localparam int unsigned IDW      = $clog2(NUM_REQ);
  localparam int unsigned CW       = $clog2(max_u(TIMEOUT, GAP_CYCLES) + 1);
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  tx_sched_state_e    state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               err_q, err_d;
  logic               accept;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDW-1:0]     arb_id;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // req_ready decodes state combinationally, so rst_n gates it to stay low during reset.
  assign accept        = (state_q == IDLE) && en && (|bus.req_valid) && rst_n;
  assign bus.req_ready = accept ? arb_gnt : '0;
  assign bus.tx_start  = (state_q == LAUNCH);
  assign bus.tx_data   = tx_data_q;
  assign grant_id      = grant_id_q;
  assign busy          = (state_q != IDLE);
  assign timeout_err   = err_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    err_d      = err_q;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_data_d  = bus.req_data[arb_id*DATA_W +: DATA_W];
          grant_id_d = arb_id;
          ptr_d      = (arb_id == IDW'(NUM_REQ - 1)) ? '0 : arb_id + IDW'(1);
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + CW'(1);
        // A done arriving on the timeout cycle wins, so no error is flagged then.
        if (bus.tx_done || (cnt_q == CW'(TIMEOUT - 1))) begin
          if (!bus.tx_done) err_d = 1'b1;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(GAP_LAST)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      err_q      <= err_d;
    end
  end

endmodule
